// File: rtl/scan_pkg.sv
// scan_pkg: shared slot geometry, FSM encoding and cyclic slot-advance helper for scan_ctrl4
package scan_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W = 2;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } state_t;
  // Next enabled slot after idx, searching cyclically; returns idx itself if it is the only one set
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] idx,
                                                  input logic [NUM_SLOTS-1:0] mask);
    logic [SLOT_W-1:0] r;
    r = idx;
    for (int k = NUM_SLOTS - 1; k > 0; k--) begin
      if (mask[idx + SLOT_W'(k)]) r = idx + SLOT_W'(k);
    end
    return r;
  endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: loadable down-counter that parks at zero and flags expiry
module scan_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] count;
  // Load wins over counting; the counter rests at zero until reloaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (count != '0) count <= count - 1'b1;
  end
  assign zero = (count == '0);
endmodule

// File: rtl/scan_ctrl4.sv
// scan_ctrl4: 4-slot display scan controller (optional slot skipping via macro SCAN_MASK_EN)
module scan_ctrl4
  import scan_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ON_CYCLES = 1000,
  parameter int BLANK_CYCLES = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [NUM_SLOTS*NIB_W-1:0] digits_in,
`ifdef SCAN_MASK_EN
  input  logic [NUM_SLOTS-1:0]    mask,
`endif
  output logic [SLOT_W-1:0]       sel_a,
  output logic                    sel_en,
  output logic [NIB_W-1:0]        digit_out,
  output logic                    busy,
  output logic                    frame_done
);
  localparam longint MAX_V = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] ON_LD = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BL_LD = CNT_W'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  if (ON_CYCLES < 1 || longint'(ON_CYCLES) > MAX_V) begin : g_bad_on
    $fatal(1, "scan_ctrl4: ON_CYCLES out of range");
  end
  if (BLANK_CYCLES < 0 || longint'(BLANK_CYCLES) > MAX_V) begin : g_bad_blank
    $fatal(1, "scan_ctrl4: BLANK_CYCLES out of range");
  end
  logic [NUM_SLOTS-1:0] msk;
`ifdef SCAN_MASK_EN
  assign msk = mask;
`else
  assign msk = '1;
`endif
  state_t state, state_n;
  logic [SLOT_W-1:0] idx_n, nxt, first;
  logic [NIB_W-1:0] dig_n;
  logic en_n, busy_n, fd_n, load, zero, last;
  logic [CNT_W-1:0] load_val;
  scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_val(load_val),
    .zero(zero)
  );
  assign nxt = next_slot(sel_a, msk);
  assign first = next_slot(SLOT_W'(NUM_SLOTS - 1), msk);
  assign last = (nxt <= sel_a);
  // Next state and next registered outputs; stop and empty mask override slot expiry
  always_comb begin
    state_n = state;
    idx_n = sel_a;
    en_n = sel_en;
    dig_n = digit_out;
    busy_n = busy;
    fd_n = 1'b0;
    load = 1'b0;
    load_val = ON_LD;
    if (state == ST_IDLE) begin
      if (run && |msk) begin
        state_n = ST_ON;
        idx_n = first;
        en_n = 1'b1;
        busy_n = 1'b1;
        dig_n = digits_in[{first, 2'b00} +: NIB_W];
        load = 1'b1;
      end
    end else if (!run || !(|msk)) begin
      state_n = ST_IDLE;
      idx_n = '0;
      en_n = 1'b0;
      busy_n = 1'b0;
    end else if (zero) begin
      if (state == ST_ON && BLANK_CYCLES > 0) begin
        state_n = ST_BLANK;
        en_n = 1'b0;
        load = 1'b1;
        load_val = BL_LD;
      end else begin
        state_n = ST_ON;
        idx_n = nxt;
        en_n = 1'b1;
        dig_n = digits_in[{nxt, 2'b00} +: NIB_W];
        load = 1'b1;
        fd_n = last;
      end
    end
  end
  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sel_a <= '0;
      sel_en <= 1'b0;
      digit_out <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      sel_a <= idx_n;
      sel_en <= en_n;
      digit_out <= dig_n;
      busy <= busy_n;
      frame_done <= fd_n;
    end
  end
endmodule
